fetch_unit: RTL

Instruction fetch and program-counter stage for the LEGv8 single-cycle processor. It holds the architectural PC and fetches 32-bit instructions from instruction memory over a request/acknowledge handshake. Each fetched instruction is presented to decode and to the sign extender (bits [25:0]). The next PC is computed from the sign extender's 64-bit `extended` output, the branch controls and the ALU zero flag.

---
 rtl/fetch_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch and program-counter stage for a LEGv8 single-cycle core.
// Holds the architectural PC and fetches one 32-bit instruction at a time
// over a request/acknowledge handshake. The instruction is held stable for
// decode while it executes. The next PC is then chosen from the register
// target (BR), the PC-relative target (B / CB taken) or PC+4.
//
// States: IDLE -> FETCH -> EXEC -> FETCH ... ; any fault -> HALT (left only by reset).
//
// Parameters
//   RESET_PC    PC value loaded on reset
//   MAX_WAIT    FETCH cycles allowed without imem_ack before a timeout (1..255)
//
// Ports
//   clk          in   1   clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   imem_req     out  1   fetch request, high only in FETCH
//   imem_addr    out  64  fetch byte address (equals pc)
//   imem_ack     in   1   imem_data valid this cycle (sampled only in FETCH)
//   imem_data    in   32  instruction word
//   instr        out  32  registered instruction
//   instr_valid  out  1   high in EXEC
//   stall        in   1   downstream hold request (sampled in EXEC)
//   extended     in   64  sign-extended, pre-shifted branch offset
//   branch       in   1   unconditional PC-relative branch
//   cbranch      in   1   conditional branch, taken when zero=1
//   zero         in   1   ALU zero flag
//   br_reg       in   1   register-indirect branch
//   reg_target   in   64  register-indirect target
//   pc           out  64  current PC
//   fault        out  2   sticky fault: 00 none, 01 misaligned, 10 timeout
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic [63:0] extended,
    input  logic        branch,
    input  logic        cbranch,
    input  logic        zero,
    input  logic        br_reg,
    input  logic [63:0] reg_target,
    output logic [63:0] pc,
    output logic [1:0]  fault
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_FETCH = 2'b01;
    localparam logic [1:0] S_EXEC  = 2'b10;
    localparam logic [1:0] S_HALT  = 2'b11;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    // Counter value seen on the last permitted FETCH cycle; no ack there means timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]  r_state;
    logic [63:0] r_pc;
    logic [31:0] r_instr;
    logic [1:0]  r_fault;
    logic [7:0]  r_wait;

    logic [63:0] w_next_pc;
    logic        w_take_rel;
    logic        w_misaligned;

    // Next-PC selection: BR has priority over B / taken CB, which beat PC+4.
    always_comb begin
        w_take_rel   = branch | (cbranch & zero);
        w_next_pc    = r_pc + 64'd4;
        if (br_reg) begin
            w_next_pc = reg_target;
        end else if (w_take_rel) begin
            w_next_pc = r_pc + extended;
        end else begin
            w_next_pc = r_pc + 64'd4;
        end
        w_misaligned = (w_next_pc[1:0] != 2'b00);
    end

    // Handshake strobes are decoded from the state register only.
    assign imem_req    = (r_state == S_FETCH);
    assign instr_valid = (r_state == S_EXEC);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign fault       = r_fault;

    // Fetch/execute sequencing, PC update, timeout and fault capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_fault <= FAULT_NONE;
            r_wait  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_data;
                        r_wait  <= 8'd0;
                        r_state <= S_EXEC;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                        // Counter is about to reach MAX_WAIT: give up.
                        if (r_wait == WAIT_LAST) begin
                            r_fault <= FAULT_TIMEOUT;
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_EXEC: begin
                    if (stall) begin
                        r_state <= S_EXEC;
                    end else if (w_misaligned) begin
                        // PC is left at the instruction that produced the bad target.
                        r_fault <= FAULT_MISALIGN;
                        r_state <= S_HALT;
                    end else begin
                        r_pc    <= w_next_pc;
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

endmodule
